cons_alloc: RTL and testbench

CONS_ALLOC -- requirements
Module: cons_alloc

---
 rtl/cons_alloc_if.sv | 25 ++
 rtl/cons_alloc.sv | 192 +++++++++++++++++++
 tb/tb_cons_alloc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cons_alloc_if.sv
// rtl/cons_alloc_if.sv - request/response/heap-write bundle for the cons-cell allocator
interface cons_alloc_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_tag;
    logic [15:0] req_car;
    logic [15:0] req_cdr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_ptr;
    logic        rsp_err;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport master (
        output req_valid, req_tag, req_car, req_cdr, rsp_ready,
        input  req_ready, rsp_valid, rsp_ptr, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_tag, req_car, req_cdr, rsp_ready,
        output req_ready, rsp_valid, rsp_ptr, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cons_alloc.sv
// rtl/cons_alloc.sv - bump allocator writing tagged lisp cells into a heap; CONS_ALLOC_STATS_EN adds alloc_count/oom_seen
module cons_alloc #(
    parameter logic [15:0] HEAP_BASE  = 16'h0001,
    parameter logic [15:0] HEAP_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    cons_alloc_if.slave bus,
`ifdef CONS_ALLOC_STATS_EN
    output logic [15:0] alloc_count,
    output logic        oom_seen,
`endif
    output logic [15:0] free_ptr
);

    localparam logic [15:0] TYPE_NUMBER    = 16'h0000;
    localparam logic [15:0] TYPE_CONS      = 16'h0001;
    localparam logic [15:0] TYPE_PRIMITIVE = 16'h0002;
    localparam logic [15:0] NIL            = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        WR_TAG,
        WR_W1,
        WR_W2,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tag_q, tag_d;
    logic [15:0] car_q, car_d;
    logic [15:0] cdr_q, cdr_d;
    logic [15:0] free_ptr_q, free_ptr_d;
    logic [15:0] rsp_ptr_q, rsp_ptr_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef CONS_ALLOC_STATS_EN
    logic [15:0] alloc_count_q, alloc_count_d;
    logic        oom_seen_q, oom_seen_d;
`endif

    logic        accept;
    logic        req_tag_ok;
    logic [1:0]  req_size;
    logic [16:0] alloc_end;
    logic        req_err;
    logic [1:0]  cur_size;
    logic        finish;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_ptr   = rsp_ptr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign free_ptr      = free_ptr_q;
`ifdef CONS_ALLOC_STATS_EN
    assign alloc_count   = alloc_count_q;
    assign oom_seen      = oom_seen_q;
`endif

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        req_tag_ok = 1'b1;
        req_size   = 2'd0;
        case (bus.req_tag)
            TYPE_CONS:      req_size = 2'd3;
            TYPE_NUMBER:    req_size = 2'd2;
            TYPE_PRIMITIVE: req_size = 2'd2;
            default:        req_tag_ok = 1'b0;
        endcase
    end

    // 17-bit sum so a cell ending past 16'hFFFF cannot wrap into a false fit
    assign alloc_end = {1'b0, free_ptr_q} + {15'd0, req_size};
    assign req_err   = !req_tag_ok || (alloc_end > {1'b0, HEAP_LIMIT});
    assign cur_size  = (tag_q == TYPE_CONS) ? 2'd3 : 2'd2;

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        car_d      = car_q;
        cdr_d      = cdr_q;
        free_ptr_d = free_ptr_q;
        rsp_ptr_d  = rsp_ptr_q;
        rsp_err_d  = rsp_err_q;
        finish     = 1'b0;
`ifdef CONS_ALLOC_STATS_EN
        alloc_count_d = alloc_count_q;
        oom_seen_d    = oom_seen_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d = bus.req_tag;
                    car_d = bus.req_car;
                    cdr_d = bus.req_cdr;
                    if (req_err) begin
                        rsp_ptr_d = NIL;
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
`ifdef CONS_ALLOC_STATS_EN
                        oom_seen_d = 1'b1;
`endif
                    end else begin
                        state_d = WR_TAG;
                    end
                end
            end
            WR_TAG: state_d = WR_W1;
            WR_W1: begin
                if (tag_q == TYPE_CONS) begin
                    state_d = WR_W2;
                end else begin
                    finish = 1'b1;
                end
            end
            WR_W2: finish = 1'b1;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pointer bump happens only once every word of the cell has been written
        if (finish) begin
            state_d    = RESP;
            rsp_ptr_d  = free_ptr_q;
            rsp_err_d  = 1'b0;
            free_ptr_d = free_ptr_q + {14'd0, cur_size};
`ifdef CONS_ALLOC_STATS_EN
            if (alloc_count_q != 16'hFFFF) begin
                alloc_count_d = alloc_count_q + 16'd1;
            end
`endif
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        case (state_q)
            WR_TAG: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = free_ptr_q;
                bus.mem_wdata = tag_q;
            end
            WR_W1: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = free_ptr_q + 16'd1;
                bus.mem_wdata = car_q;
            end
            WR_W2: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = free_ptr_q + 16'd2;
                bus.mem_wdata = cdr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tag_q      <= 16'h0000;
            car_q      <= 16'h0000;
            cdr_q      <= 16'h0000;
            free_ptr_q <= HEAP_BASE;
            rsp_ptr_q  <= 16'h0000;
            rsp_err_q  <= 1'b0;
`ifdef CONS_ALLOC_STATS_EN
            alloc_count_q <= 16'h0000;
            oom_seen_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            car_q      <= car_d;
            cdr_q      <= cdr_d;
            free_ptr_q <= free_ptr_d;
            rsp_ptr_q  <= rsp_ptr_d;
            rsp_err_q  <= rsp_err_d;
`ifdef CONS_ALLOC_STATS_EN
            alloc_count_q <= alloc_count_d;
            oom_seen_q    <= oom_seen_d;
`endif
        end
    end

endmodule

// File: tb/tb_cons_alloc.sv
// tb/tb_cons_alloc.sv - directed bench for cons_alloc, default heap and a 6-word-limit heap
module tb_cons_alloc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_tag   = 16'h0;
    logic [15:0] req_car   = 16'h0;
    logic [15:0] req_cdr   = 16'h0;
    logic        rsp_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cons_alloc_if bus0();
    cons_alloc_if bus1();

    logic [15:0] fp0, fp1;
`ifdef CONS_ALLOC_STATS_EN
    logic [15:0] ac0, ac1;
    logic        oom0, oom1;
`endif

    assign bus0.req_valid = req_valid & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus0.rsp_ready = rsp_ready & ~sel;
    assign bus1.rsp_ready = rsp_ready & sel;
    assign bus0.req_tag = req_tag;
    assign bus1.req_tag = req_tag;
    assign bus0.req_car = req_car;
    assign bus1.req_car = req_car;
    assign bus0.req_cdr = req_cdr;
    assign bus1.req_cdr = req_cdr;

    cons_alloc u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus0.slave),
`ifdef CONS_ALLOC_STATS_EN
        .alloc_count (ac0),
        .oom_seen    (oom0),
`endif
        .free_ptr    (fp0)
    );

    cons_alloc #(.HEAP_LIMIT(16'h0006)) u_lim (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus1.slave),
`ifdef CONS_ALLOC_STATS_EN
        .alloc_count (ac1),
        .oom_seen    (oom1),
`endif
        .free_ptr    (fp1)
    );

    wire        o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
    wire        o_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    wire [15:0] o_rsp_ptr   = sel ? bus1.rsp_ptr   : bus0.rsp_ptr;
    wire        o_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
    wire        o_mem_we    = sel ? bus1.mem_we    : bus0.mem_we;
    wire [15:0] o_mem_addr  = sel ? bus1.mem_addr  : bus0.mem_addr;
    wire [15:0] o_mem_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
    wire [15:0] o_free_ptr  = sel ? fp1 : fp0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_ptr", o_rsp_ptr, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_mem_we", o_mem_we, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        check("rst_free_ptr", o_free_ptr, 16'h0001);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", o_req_ready, 1);
    endtask

    task automatic issue(input logic [15:0] tag, input logic [15:0] car, input logic [15:0] cdr);
        @(negedge clk);
        req_tag = tag;
        req_car = car;
        req_cdr = cdr;
        req_valid = 1'b1;
        check("issue_req_ready", o_req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Starts just after the accept edge; ends on the negedge where the response is visible
    task automatic expect_rsp(input int lat, input logic [15:0] ptr, input logic err,
                              input logic [15:0] free_after, input logic [15:0] tag,
                              input logic [15:0] car, input logic [15:0] cdr);
        logic [15:0] wd;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                wd = (k == 1) ? tag : ((k == 2) ? car : cdr);
                check("wr_we", o_mem_we, 1);
                check("wr_addr", o_mem_addr, ptr + 16'(k - 1));
                check("wr_data", o_mem_wdata, wd);
                check("wr_no_rsp", o_rsp_valid, 0);
            end else begin
                check("rsp_valid", o_rsp_valid, 1);
                check("rsp_ptr", o_rsp_ptr, ptr);
                check("rsp_err", o_rsp_err, err);
                check("rsp_no_we", o_mem_we, 0);
                check("rsp_free_ptr", o_free_ptr, free_after);
            end
        end
    endtask

    task automatic handshake(input int hold, input logic [15:0] ptr, input logic err);
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", o_rsp_valid, 1);
            check("hold_ptr", o_rsp_ptr, ptr);
            check("hold_err", o_rsp_err, err);
            check("hold_req_ready", o_req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("hs_rsp_valid", o_rsp_valid, 0);
        check("hs_req_ready", o_req_ready, 1);
    endtask

    initial begin
        sel = 1'b0;
        do_reset();

        issue(16'h0000, 16'h002A, 16'h0000);
        expect_rsp(3, 16'h0001, 1'b0, 16'h0003, 16'h0000, 16'h002A, 16'h0000);
        handshake(0, 16'h0001, 1'b0);

        issue(16'h0001, 16'h0001, 16'h0000);
        expect_rsp(4, 16'h0003, 1'b0, 16'h0006, 16'h0001, 16'h0001, 16'h0000);
        handshake(1, 16'h0003, 1'b0);

        issue(16'h0007, 16'h1111, 16'h2222);
        expect_rsp(1, 16'h0000, 1'b1, 16'h0006, 16'h0, 16'h0, 16'h0);
        handshake(0, 16'h0000, 1'b1);

        // Next request pending across a 5-cycle stall must only be taken after the handshake
        issue(16'h0002, 16'h0005, 16'h0000);
        expect_rsp(3, 16'h0006, 1'b0, 16'h0008, 16'h0002, 16'h0005, 16'h0000);
        req_tag = 16'h0000;
        req_car = 16'h1234;
        req_cdr = 16'h0000;
        req_valid = 1'b1;
        handshake(5, 16'h0006, 1'b0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        expect_rsp(3, 16'h0008, 1'b0, 16'h000A, 16'h0000, 16'h1234, 16'h0000);
        handshake(0, 16'h0008, 1'b0);

        // Reset while the cons car word is being written
        issue(16'h0001, 16'hAAAA, 16'hBBBB);
        @(negedge clk);
        check("mid_tag_we", o_mem_we, 1);
        @(negedge clk);
        check("mid_w1_addr", o_mem_addr, 16'h000B);
        check("mid_w1_data", o_mem_wdata, 16'hAAAA);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_we", o_mem_we, 0);
        check("abort_rsp", o_rsp_valid, 0);
        check("abort_free", o_free_ptr, 16'h0001);
        check("abort_req_ready", o_req_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle_rsp", o_rsp_valid, 0);
            check("abort_idle_we", o_mem_we, 0);
        end
`ifdef CONS_ALLOC_STATS_EN
        check("abort_alloc_count", ac0, 0);
        check("abort_oom", oom0, 0);
`endif

        // Small heap: exclusive limit 6
        sel = 1'b1;
        do_reset();
        issue(16'h0001, 16'h0000, 16'h0000);
        expect_rsp(4, 16'h0001, 1'b0, 16'h0004, 16'h0001, 16'h0000, 16'h0000);
        handshake(0, 16'h0001, 1'b0);

        issue(16'h0001, 16'h0001, 16'h0001);
        expect_rsp(1, 16'h0000, 1'b1, 16'h0004, 16'h0, 16'h0, 16'h0);
        handshake(0, 16'h0000, 1'b1);

        issue(16'h0000, 16'h0055, 16'h0000);
        expect_rsp(3, 16'h0004, 1'b0, 16'h0006, 16'h0000, 16'h0055, 16'h0000);
        handshake(0, 16'h0004, 1'b0);

        issue(16'h0000, 16'h0066, 16'h0000);
        expect_rsp(1, 16'h0000, 1'b1, 16'h0006, 16'h0, 16'h0, 16'h0);
        handshake(0, 16'h0000, 1'b1);
`ifdef CONS_ALLOC_STATS_EN
        check("lim_alloc_count", ac1, 2);
        check("lim_oom", oom1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
